instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- DDR-side responder to the top controller's instruction-fetch request.
- On a fetch_req level, issues burst reads to external memory and writes returned beats into an on-chip instruction buffer.
- Raises i_mem_full when the batch is loaded, serves 1-cycle-latency reads to the controller, and raises i_mem_empty once every loaded instruction has been read.
- Tracks a program pointer across batches and wraps it to prog_base at the end of the program.

Parameters:
- DATA_W, 64, instruction/beat width
- ADDR_W, 10, buffer address width
- DEPTH, 1024, buffer entries (must be ≤ 2**ADDR_W)
- BURST_LEN, 16, max beats per DDR read request (power of 2, ≤ 256)
- DDR_AW, 32, external byte address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prog_base  in  DDR_AW  byte address of instruction 0; sampled in IDLE on fetch_req
- prog_len  in  16  total instructions in program; sampled with prog_base; 0 treated as 1
- fetch_req  in  1  level request from controller to (re)fill buffer
- ddr_rd_req  out  1  read request valid
- ddr_rd_addr  out  DDR_AW  burst start byte address
- ddr_rd_len  out  8  beats minus 1
- ddr_rd_ack  in  1  request accepted
- ddr_rd_valid  in  1  read beat valid
- ddr_rd_data  in  DATA_W  read beat
- ddr_rd_last  in  1  final beat of burst
- i_mem_rd_enable  in  1  controller read strobe
- i_mem_addr  in  ADDR_W  controller read address
- i_mem_dout  out  DATA_W  registered read data
- i_mem_empty  out  1  all loaded instructions consumed
- i_mem_full  out  1  batch loaded, buffer valid
- prog_wrap  out  1  1-cycle pulse when program pointer wraps
- load_err  out  1  sticky beat-count error (optional feature only; else tied 0)

Behaviour:
- Reset: ddr_rd_req=0, ddr_rd_addr=0, ddr_rd_len=0, i_mem_dout=0, i_mem_empty=1, i_mem_full=0, prog_wrap=0, load_err=0; state IDLE; counters 0; program pointer = 0 until first sample.
- States: IDLE -> REQ -> DATA -> (REQ | FILLED) -> IDLE.
- IDLE: empty=1, full=0. On fetch_req=1: batch = min(DEPTH, remaining), where remaining = prog_len − ptr. First-ever sample also latches prog_base/prog_len. Clear wr_idx and rd_cnt; go to REQ.
- REQ: ddr_rd_req=1; ddr_rd_addr = prog_base + 8*ptr (8 = DATA_W/8); ddr_rd_len = min(BURST_LEN, batch − wr_idx) − 1. Hold all request fields stable until ddr_rd_ack=1. The ack cycle drops req and moves to DATA.
- DATA: each ddr_rd_valid writes ddr_rd_data to buffer[wr_idx], then wr_idx++ and ptr++.
  - On ddr_rd_last: if wr_idx+1 == batch go to FILLED, else go to REQ.
  - Beats arriving when wr_idx == batch are dropped.
  - ddr_rd_valid outside DATA is ignored.
- FILLED: i_mem_full=1, i_mem_empty=0.
  - Each i_mem_rd_enable: i_mem_dout <= buffer[i_mem_addr] next cycle; rd_cnt++.
  - When rd_cnt reaches batch: i_mem_full=0 and i_mem_empty=1 on the same edge; go to IDLE.
- Reads outside FILLED still return buffer data but do not count.
- ptr == prog_len at batch end: ptr <= 0 and prog_wrap pulses 1 cycle; the next fetch reloads from prog_base.
- Write and read never overlap (different states), so the buffer is simple dual-port with no bypass.
- fetch_req is ignored outside IDLE.
- rst mid-burst aborts immediately: req drops; late DDR beats are dropped in IDLE.

Optional Feature:
- Macro INSTR_LOADER_LAST_CHECK_EN.
- Defined: in DATA, ddr_rd_last not coinciding with the expected final beat of the burst, or a beat arriving after the expected final beat, sets load_err, which stays set until rst. The FSM proceeds on the expected count, not on ddr_rd_last.
- Undefined: load_err is tied 0 and burst end is taken from ddr_rd_last alone.

Decomposition:
- Package instr_loader_pkg: state enum (IDLE, REQ, DATA, FILLED), BYTES_PER_INSTR = DATA_W/8, DDR_LEN_W = 8.
- One sub-module: instr_buf_sdp, a DEPTH×DATA_W simple dual-port RAM with registered read port.

Test Plan:
- DEPTH=1024, BURST_LEN=16, prog_base=0x1000, prog_len=40, fetch_req=1 -> three requests: addr 0x1000 len 15, 0x1080 len 15, 0x1100 len 7; full=1 after 40th beat; empty=0.
- Read addr 0..39 with rd_enable pulses -> i_mem_dout equals beat k one cycle after each read; on 40th read, full->0 and empty->1 same edge; prog_wrap pulses.
- DDR holds ddr_rd_ack low 5 cycles -> ddr_rd_req/addr/len stable all 5 cycles; no writes.
- prog_len=2000 -> batch 1 is 1024 beats; after consumption the next fetch starts at 0x1000+8*1024=0x3000 with batch 976; then wrap.
- rst asserted on beat 7 of a burst -> next cycle all outputs at reset values; trailing beats ignored; new fetch restarts from ptr 0.
- With INSTR_LOADER_LAST_CHECK_EN, ddr_rd_last on beat 10 of a 16-beat burst -> load_err=1 and sticky; FSM completes after 16 beats. Without the macro, the same stimulus ends the burst at beat 10 and load_err stays 0.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// The optional beat-count checker is enabled with INSTR_LOADER_LAST_CHECK_EN.
package instr_loader_pkg;

  // Loader FSM states: idle, issuing a DDR request, receiving beats,
  // and holding a loaded batch for the controller.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DATA   = 2'd2,
    FILLED = 2'd3
  } state_t;

  // Byte stride of one instruction for the default 64-bit instruction width.
  localparam int DEFAULT_DATA_W  = 64;
  localparam int BYTES_PER_INSTR = DEFAULT_DATA_W / 8;

  // Width of the DDR burst length field (beats minus one).
  localparam int DDR_LEN_W = 8;

  // Unsigned minimum, used for batch and burst sizing.
  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/instr_loader_buf_sdp.sv
// Simple dual-port instruction buffer: one write port fed by DDR beats and
// one read port with a registered output for the controller. Writes and
// reads happen in different loader states, so no read-during-write bypass.
module instr_buf_sdp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store one beat per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: one-cycle latency, output register cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: on a fetch request, reads the next batch of the program
// from DDR in bursts, stores it in the on-chip buffer, then serves the
// controller until every loaded instruction has been read once.
// A program pointer carries across batches and wraps to the program base.
//
// Optional build macro INSTR_LOADER_LAST_CHECK_EN: bursts end on the expected
// beat count and any ddr_rd_last disagreement or surplus beat sets a sticky
// load_err. Without it, bursts end on ddr_rd_last and load_err is tied low.
//
// DDR request handshake: ddr_rd_req/ddr_rd_addr/ddr_rd_len are held stable
// while ddr_rd_req is high and the request is taken on the cycle ddr_rd_ack
// is high; beats are accepted on every cycle ddr_rd_valid is high in DATA.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 16,
  parameter int DDR_AW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DDR_AW-1:0]    prog_base,
  input  logic [15:0]          prog_len,
  input  logic                 fetch_req,
  output logic                 ddr_rd_req,
  output logic [DDR_AW-1:0]    ddr_rd_addr,
  output logic [DDR_LEN_W-1:0] ddr_rd_len,
  input  logic                 ddr_rd_ack,
  input  logic                 ddr_rd_valid,
  input  logic [DATA_W-1:0]    ddr_rd_data,
  input  logic                 ddr_rd_last,
  input  logic                 i_mem_rd_enable,
  input  logic [ADDR_W-1:0]    i_mem_addr,
  output logic [DATA_W-1:0]    i_mem_dout,
  output logic                 i_mem_empty,
  output logic                 i_mem_full,
  output logic                 prog_wrap,
  output logic                 load_err,
  output logic [1:0]           dbg_state
);

  localparam int BPI   = DATA_W / 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t state, state_nxt;

  // Program context: latched on the first fetch after reset.
  logic [DDR_AW-1:0] base_q;
  logic [15:0]       len_q;
  logic              prog_seen;
  logic [15:0]       ptr;

  // Batch bookkeeping.
  logic [CNT_W-1:0]  batch;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  rd_cnt;

  logic [15:0]       len_in_eff;
  logic [15:0]       len_use;
  logic [16:0]       remaining;
  logic [CNT_W-1:0]  batch_new;
  logic [CNT_W-1:0]  left;
  logic [8:0]        beats;
  logic [CNT_W-1:0]  wr_idx_inc;
  logic [CNT_W-1:0]  rd_cnt_inc;
  logic              beat_ok;
  logic              burst_end;
  logic              load_done;
  logic              rd_fire;
  logic              rd_done;
  logic              at_end;

  assign dbg_state = state;

  // Sizing: batch is the rest of the program capped at buffer depth; each
  // burst is the rest of the batch capped at the burst limit.
  always_comb begin
    len_in_eff = (prog_len == 16'd0) ? 16'd1 : prog_len;
    len_use    = prog_seen ? len_q : len_in_eff;
    remaining  = {1'b0, len_use} - {1'b0, ptr};
    batch_new  = CNT_W'(min_u32(32'(remaining), 32'(DEPTH)));
    left       = batch - wr_idx;
    beats      = 9'(min_u32(32'(left), 32'(BURST_LEN)));
    wr_idx_inc = wr_idx + CNT_W'(1);
    rd_cnt_inc = rd_cnt + CNT_W'(1);
  end

  // Beat acceptance, batch completion and controller read accounting.
  always_comb begin
    beat_ok   = (state == DATA) && ddr_rd_valid && (wr_idx < batch);
    load_done = beat_ok ? (wr_idx_inc >= batch) : (wr_idx >= batch);
    rd_fire   = (state == FILLED) && i_mem_rd_enable;
    rd_done   = rd_fire && (rd_cnt_inc == batch);
    at_end    = (ptr == len_q);
  end

`ifdef INSTR_LOADER_LAST_CHECK_EN
  logic [8:0] burst_beats;
  logic [8:0] beat_cnt;
  logic       exp_final;
  logic       err_q;

  assign exp_final = (beat_cnt == (burst_beats - 9'd1));
  assign burst_end = (state == DATA) && ddr_rd_valid && exp_final;
  assign load_err  = err_q;

  // Count beats against the granted burst size and flag any disagreement
  // with ddr_rd_last or any beat that shows up once the burst is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_beats <= 9'd0;
      beat_cnt    <= 9'd0;
      err_q       <= 1'b0;
    end else begin
      if ((state == REQ) && ddr_rd_ack) begin
        burst_beats <= beats;
        beat_cnt    <= 9'd0;
      end else if ((state == DATA) && ddr_rd_valid) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
      if ((state == DATA) && ddr_rd_valid && (ddr_rd_last != exp_final)) begin
        err_q <= 1'b1;
      end
      if (((state == REQ) || (state == FILLED)) && ddr_rd_valid) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign burst_end = (state == DATA) && ddr_rd_valid && ddr_rd_last;
  assign load_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    ddr_rd_req  = 1'b0;
    ddr_rd_addr = '0;
    ddr_rd_len  = '0;
    i_mem_full  = 1'b0;
    i_mem_empty = 1'b1;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        ddr_rd_req  = 1'b1;
        ddr_rd_addr = base_q + (DDR_AW'(ptr) * DDR_AW'(BPI));
        ddr_rd_len  = DDR_LEN_W'(beats - 9'd1);
        if (ddr_rd_ack) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (burst_end) begin
          state_nxt = load_done ? FILLED : REQ;
        end
      end
      FILLED: begin
        i_mem_full  = 1'b1;
        i_mem_empty = 1'b0;
        if (rd_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Program pointer, batch counters and the wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= 16'd0;
      prog_seen <= 1'b0;
      ptr       <= 16'd0;
      batch     <= '0;
      wr_idx    <= '0;
      rd_cnt    <= '0;
      prog_wrap <= 1'b0;
    end else begin
      prog_wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req) begin
            batch  <= batch_new;
            wr_idx <= '0;
            rd_cnt <= '0;
            if (!prog_seen) begin
              base_q    <= prog_base;
              len_q     <= len_in_eff;
              prog_seen <= 1'b1;
            end
          end
        end
        DATA: begin
          if (beat_ok) begin
            wr_idx <= wr_idx_inc;
            ptr    <= ptr + 16'd1;
          end
        end
        FILLED: begin
          if (rd_fire) begin
            rd_cnt <= rd_cnt_inc;
            if (rd_done && at_end) begin
              ptr       <= 16'd0;
              prog_wrap <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  instr_buf_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (beat_ok),
    .waddr (ADDR_W'(wr_idx)),
    .wdata (ddr_rd_data),
    .re    (i_mem_rd_enable),
    .raddr (i_mem_addr),
    .rdata (i_mem_dout)
  );

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: a reactive DDR responder whose memory content
// is a function of the byte address, a batch/burst planner computed from the
// program length, and a scoreboard for controller reads.
module tb_instr_loader;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 10;
  localparam int DEPTH     = 1024;
  localparam int BURST_LEN = 16;
  localparam int DDR_AW    = 32;

  logic              clk;
  logic              rst;
  logic [DDR_AW-1:0] prog_base;
  logic [15:0]       prog_len;
  logic              fetch_req;
  logic              ddr_rd_req;
  logic [DDR_AW-1:0] ddr_rd_addr;
  logic [7:0]        ddr_rd_len;
  logic              ddr_rd_ack;
  logic              ddr_rd_valid;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_last;
  logic              i_mem_rd_enable;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [DATA_W-1:0] i_mem_dout;
  logic              i_mem_empty;
  logic              i_mem_full;
  logic              prog_wrap;
  logic              load_err;
  logic [1:0]        dbg_state;

  instr_loader #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN),
    .DDR_AW    (DDR_AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .prog_base       (prog_base),
    .prog_len        (prog_len),
    .fetch_req       (fetch_req),
    .ddr_rd_req      (ddr_rd_req),
    .ddr_rd_addr     (ddr_rd_addr),
    .ddr_rd_len      (ddr_rd_len),
    .ddr_rd_ack      (ddr_rd_ack),
    .ddr_rd_valid    (ddr_rd_valid),
    .ddr_rd_data     (ddr_rd_data),
    .ddr_rd_last     (ddr_rd_last),
    .i_mem_rd_enable (i_mem_rd_enable),
    .i_mem_addr      (i_mem_addr),
    .i_mem_dout      (i_mem_dout),
    .i_mem_empty     (i_mem_empty),
    .i_mem_full      (i_mem_full),
    .prog_wrap       (prog_wrap),
    .load_err        (load_err),
    .dbg_state       (dbg_state)
  );

`ifdef INSTR_LOADER_LAST_CHECK_EN
  localparam bit LAST_CHECK = 1'b1;
`else
  localparam bit LAST_CHECK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] seed_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // DDR content: a scrambled function of the byte address.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ seed_word[63:32], (a * 32'h9E3779B1) ^ seed_word[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst             = 1'b1;
    fetch_req       = 1'b0;
    ddr_rd_ack      = 1'b0;
    ddr_rd_valid    = 1'b0;
    ddr_rd_last     = 1'b0;
    ddr_rd_data     = '0;
    i_mem_rd_enable = 1'b0;
    i_mem_addr      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req"},   ddr_rd_req,  0);
    check({pfx, "_addr"},  ddr_rd_addr, 0);
    check({pfx, "_len"},   ddr_rd_len,  0);
    check({pfx, "_dout"},  i_mem_dout,  0);
    check({pfx, "_empty"}, i_mem_empty, 1);
    check({pfx, "_full"},  i_mem_full,  0);
    check({pfx, "_wrap"},  prog_wrap,   0);
    check({pfx, "_err"},   load_err,    0);
  endtask

  task automatic wait_req(output bit seen);
    int n;
    n = 0;
    while (ddr_rd_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = (ddr_rd_req === 1'b1);
  endtask

  // Answer one DDR request: check its fields, optionally stall the ack while
  // checking the request stays put, then stream exp_len+1 beats.
  // early >= 0 puts ddr_rd_last on that beat instead of the final one.
  task automatic serve_burst(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                             input int early, input int hold);
    bit seen;
    int gap;
    wait_req(seen);
    check("req_valid", seen, 1);
    check("req_addr", ddr_rd_addr, exp_addr);
    check("req_len", ddr_rd_len, exp_len);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("req_hold", {ddr_rd_req, ddr_rd_addr, ddr_rd_len}, {1'b1, exp_addr, exp_len});
    end
    ddr_rd_ack = 1'b1;
    @(negedge clk);
    ddr_rd_ack = 1'b0;
    check("req_drop", ddr_rd_req, 0);
    for (int i = 0; i <= int'(exp_len); i++) begin
      ddr_rd_valid = 1'b0;
      ddr_rd_last  = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = mem_word(exp_addr + 32'(8 * i));
      ddr_rd_last  = (early >= 0) ? (i == early) : (i == int'(exp_len));
      @(negedge clk);
    end
    ddr_rd_valid = 1'b0;
    ddr_rd_last  = 1'b0;
  endtask

  // Reference plan for one batch: bursts of up to BURST_LEN instructions
  // starting at base + 8*start_ptr, advancing by what the loader accepted.
  task automatic load_batch(input logic [31:0] base, input int start_ptr, input int batch,
                            input int early, input int hold0);
    int loaded;
    int n;
    int el;
    bit first;
    loaded = 0;
    first  = 1'b1;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    while (loaded < batch) begin
      n  = (batch - loaded > BURST_LEN) ? BURST_LEN : batch - loaded;
      el = first ? early : -1;
      serve_burst(base + 32'(8 * (start_ptr + loaded)), 8'(n - 1), el,
                  first ? hold0 : int'($urandom_range(0, 2)));
      if (!LAST_CHECK && el >= 0 && el < n - 1) loaded += el + 1;
      else loaded += n;
      first = 1'b0;
      if (loaded < batch) check("full_mid_load", i_mem_full, 0);
    end
    check("full_after_load", i_mem_full, 1);
    check("empty_after_load", i_mem_empty, 0);
  endtask

  // Controller consumes n reads; the last read ends the batch.
  task automatic read_batch(input logic [31:0] base, input int start_ptr, input int n,
                            input bit random_order, input bit exp_wrap);
    int a;
    for (int k = 0; k < n; k++) begin
      a = random_order ? int'($urandom_range(0, n - 1)) : k;
      i_mem_rd_enable = 1'b1;
      i_mem_addr      = ADDR_W'(a);
      exp_q.push_back(mem_word(base + 32'(8 * (start_ptr + a))));
      @(negedge clk);
      i_mem_rd_enable = 1'b0;
      check("rd_data", i_mem_dout, exp_q.pop_front());
      if (k == n - 2) check("full_before_last_rd", i_mem_full, 1);
      if (k == n - 1) begin
        check("full_after_last_rd", i_mem_full, 0);
        check("empty_after_last_rd", i_mem_empty, 1);
        check("wrap_pulse", prog_wrap, exp_wrap);
      end else if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
      end
    end
    if (exp_wrap) begin
      @(negedge clk);
      check("wrap_one_cycle", prog_wrap, 0);
    end
  endtask

  // A read while idle still returns buffer data and changes nothing.
  task automatic idle_read(input logic [31:0] base, input int start_ptr);
    i_mem_rd_enable = 1'b1;
    i_mem_addr      = '0;
    @(negedge clk);
    i_mem_rd_enable = 1'b0;
    check("idle_rd_data", i_mem_dout, mem_word(base + 32'(8 * start_ptr)));
    check("idle_rd_empty", i_mem_empty, 1);
    check("idle_rd_no_req", ddr_rd_req, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] base;
    int          len;
    int          eff;
    bit          seen;

    seed_word = {$urandom, $urandom};
    prog_base = '0;
    prog_len  = '0;
    do_reset();
    check_reset_outputs("reset");

    // 40-instruction program: three bursts, stalled first ack, sequential reads.
    prog_base = 32'h1000;
    prog_len  = 16'd40;
    load_batch(32'h1000, 0, 40, -1, 5);
    read_batch(32'h1000, 0, 40, 1'b0, 1'b1);
    idle_read(32'h1000, 0);
    // After the wrap the next fetch starts again at the base.
    load_batch(32'h1000, 0, 40, -1, 0);
    read_batch(32'h1000, 0, 40, 1'b1, 1'b1);

    // Program longer than the buffer: 1024 then 976, then wrap.
    do_reset();
    prog_base = 32'h1000;
    prog_len  = 16'd2000;
    load_batch(32'h1000, 0, 1024, -1, 0);
    read_batch(32'h1000, 0, 1024, 1'b1, 1'b0);
    // Program inputs only matter on the first fetch after reset.
    prog_base = 32'hDEAD_0000;
    prog_len  = 16'd5;
    load_batch(32'h1000, 1024, 976, -1, 0);
    read_batch(32'h1000, 1024, 976, 1'b1, 1'b1);
    load_batch(32'h1000, 0, 1024, -1, 0);

    // Random short programs, including a zero length.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      base = $urandom & 32'hFFFF_FFF8;
      len  = (t == 0) ? 0 : int'($urandom_range(1, 90));
      eff  = (len == 0) ? 1 : len;
      prog_base = base;
      prog_len  = 16'(len);
      load_batch(base, 0, eff, -1, int'($urandom_range(0, 3)));
      read_batch(base, 0, eff, 1'b1, 1'b1);
    end

    // Reset on beat 7 of a burst; trailing beats must be ignored.
    do_reset();
    prog_base = 32'h2000;
    prog_len  = 16'd48;
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_req(seen);
    check("rst_req_valid", seen, 1);
    check("rst_req_addr", ddr_rd_addr, 32'h2000);
    check("rst_req_len", ddr_rd_len, 15);
    ddr_rd_ack = 1'b1;
    @(negedge clk);
    ddr_rd_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ddr_rd_valid = 1'b1;
      ddr_rd_data  = mem_word(32'h2000 + 32'(8 * i));
      ddr_rd_last  = (i == 15);
      if (i == 7) rst = 1'b1;
      @(negedge clk);
      if (i == 7) begin
        rst = 1'b0;
        check_reset_outputs("mid_burst_rst");
      end
    end
    ddr_rd_valid = 1'b0;
    ddr_rd_last  = 1'b0;
    @(negedge clk);
    check("post_rst_req", ddr_rd_req, 0);
    check("post_rst_full", i_mem_full, 0);
    check("post_rst_empty", i_mem_empty, 1);
    prog_base = 32'h6000;
    prog_len  = 16'd20;
    load_batch(32'h6000, 0, 20, -1, 1);
    read_batch(32'h6000, 0, 20, 1'b1, 1'b1);
    check("post_rst_err", load_err, 0);

    // ddr_rd_last on beat 10 of a 16-beat burst.
    do_reset();
    prog_base = 32'h4000;
    prog_len  = 16'd16;
    load_batch(32'h4000, 0, 16, 9, 0);
    check("early_last_err", load_err, LAST_CHECK);
    read_batch(32'h4000, 0, 16, 1'b0, 1'b1);
    check("early_last_err_sticky", load_err, LAST_CHECK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
